rs_bank: RTL and testbench
==========================

Name: rs_bank

Overview:
Parametrised reservation-station bank serving one functional-unit class (add, mul, ld or st); one instance per class. It accepts one dispatched instruction per cycle into the lowest free entry and returns that entry's tag. It snoops the common data bus (CDB) to wake waiting operands, and issues the oldest ready entry to its functional unit over a valid/ready handshake. An entry's tag stays reserved until the CDB broadcasts that tag, which preserves Tomasulo tag uniqueness.

Parameters:
NUM_ENTRIES, 4, number of RS entries (2..16)
DATA_W, 32, operand/result width
TAG_W, 3, tag width; must hold BASE_TAG+NUM_ENTRIES-1
OPC_W, 4, opcode width passed through to the FU
BASE_TAG, 0, tag of entry 0; entry i owns tag BASE_TAG+i

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one FREE entry
disp_op  in  OPC_W  opcode
disp_s1_rdy  in  1  source 1 value valid
disp_s1_tag  in  TAG_W  source 1 producer tag
disp_s1_val  in  DATA_W  source 1 value
disp_s2_rdy  in  1  source 2 value valid
disp_s2_tag  in  TAG_W  source 2 producer tag
disp_s2_val  in  DATA_W  source 2 value
disp_tag  out  TAG_W  tag given to the accepted dispatch
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_val  in  DATA_W  broadcast result
iss_valid  out  1  an entry is ready to issue
iss_ready  in  1  FU accepts operands
iss_op  out  OPC_W  issued opcode
iss_a  out  DATA_W  operand A
iss_b  out  DATA_W  operand B
iss_tag  out  TAG_W  tag of issued entry
free_count  out  $clog2(NUM_ENTRIES+1)  number of FREE entries

Behaviour:
- Entry state: FREE, WAIT (one or both sources pending), RDY, ISSUED. Each entry also holds op, per-source rdy/tag/val, and an age stamp.
- Reset (rst=1): all entries FREE, age counter 0. Outputs: disp_ready=1, free_count=NUM_ENTRIES, iss_valid=0, disp_tag=BASE_TAG. iss_op/iss_a/iss_b/iss_tag=0 whenever iss_valid=0. rst overrides flush, dispatch and CDB, including mid-operation.
- flush=1 (rst=0): all entries go FREE next cycle. Dispatch, issue and CDB in that cycle are ignored.
- Dispatch: accepted when disp_valid && disp_ready. The target is the lowest-index FREE entry.
  - disp_tag = BASE_TAG + that index, combinational from current state.
  - The entry goes to RDY if both sources are ready after bypass, else WAIT. It takes the current age stamp, then the age counter increments (wraps; comparison is wrap-safe, since at most NUM_ENTRIES are live).
- Dispatch bypass: a source with rdy=0 whose tag equals cdb_tag while cdb_valid=1 is captured as ready with cdb_val in the same cycle.
- Wakeup: on cdb_valid, every WAIT entry's pending source with a matching tag latches cdb_val and sets rdy. The entry becomes RDY next cycle once both are ready. Ready sources are never overwritten.
- Free: on cdb_valid, an ISSUED entry whose own tag equals cdb_tag goes FREE next cycle. cdb_tag equal to a FREE, WAIT or RDY entry's own tag is ignored for that entry.
- Issue: iss_valid = any RDY entry. The selected entry is the RDY entry with the oldest age stamp. iss_* are combinational from the selected entry.
  - On iss_valid && iss_ready the entry goes ISSUED.
  - While iss_ready=0, the selection and iss_* stay stable unless an older entry becomes RDY.
- Latency: a dispatch with both sources ready can issue the next cycle at the earliest. A CDB wakeup allows issue the next cycle.
- disp_ready and free_count reflect current-cycle state only. An entry freed this cycle is allocatable next cycle. Dispatch with disp_ready=0 is dropped; the dispatcher must hold its request.
- Simultaneous dispatch, issue, wakeup and free in one cycle are all legal and independent. One CDB broadcast per cycle.

Test Plan:
- Reset, then dispatch op=1, s1=(rdy,5), s2=(rdy,7) with iss_ready=1 -> disp_tag=BASE_TAG, next cycle iss_valid=1, iss_a=5, iss_b=7, iss_tag=0. After cdb_tag=0 the entry is FREE and free_count=4.
- Dispatch entry 0 with s1 waiting on tag 6, then entry 1 fully ready; iss_ready=1 -> entry 1 issues first. cdb(6,0x10) -> entry 0 issues the next cycle with iss_a=0x10.
- Dispatch s2 pending on tag 5 in the same cycle as cdb(5,0xAB) -> entry captured RDY, iss_b=0xAB the next cycle.
- Fill all 4 entries with iss_ready=0 -> disp_ready=0 and free_count=0. A 5th dispatch is dropped. Issue entry 2 and broadcast tag 2 -> disp_ready=1, and the next dispatch gets disp_tag=2.
- Two RDY entries (ages 3 and 1) with iss_ready=0 for 3 cycles -> iss_tag stays the age-1 entry. Raising iss_ready issues it, then the age-3 entry.
- 3 entries live, assert flush mid-operation -> next cycle free_count=4 and iss_valid=0. rst asserted during a dispatch -> the dispatch is discarded and reset values appear.

Source files
------------

// File: rtl/rs_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank_if
// Description : Dispatch / CDB / issue bundle for one reservation-station
//               bank.
//               master : dispatcher + CDB + functional-unit side
//               slave  : the rs_bank itself
//               Signals:
//                 flush                   clear every entry
//                 disp_valid/disp_ready   dispatch handshake
//                 disp_op, disp_s{1,2}_*  dispatched opcode and sources
//                 disp_tag                tag given to the accepted dispatch
//                 cdb_valid/tag/val       common data bus broadcast
//                 iss_valid/iss_ready     issue handshake to the FU
//                 iss_op/a/b/tag          issued opcode, operands, tag
//                 free_count              number of FREE entries
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_bank_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 3,
    parameter int OPC_W       = 4
);
    localparam int c_cnt_w = $clog2(NUM_ENTRIES + 1);

    logic               flush;
    logic               disp_valid;
    logic               disp_ready;
    logic [OPC_W-1:0]   disp_op;
    logic               disp_s1_rdy;
    logic [TAG_W-1:0]   disp_s1_tag;
    logic [DATA_W-1:0]  disp_s1_val;
    logic               disp_s2_rdy;
    logic [TAG_W-1:0]   disp_s2_tag;
    logic [DATA_W-1:0]  disp_s2_val;
    logic [TAG_W-1:0]   disp_tag;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]  cdb_val;
    logic               iss_valid;
    logic               iss_ready;
    logic [OPC_W-1:0]   iss_op;
    logic [DATA_W-1:0]  iss_a;
    logic [DATA_W-1:0]  iss_b;
    logic [TAG_W-1:0]   iss_tag;
    logic [c_cnt_w-1:0] free_count;

    modport master (
        output flush, disp_valid, disp_op,
        output disp_s1_rdy, disp_s1_tag, disp_s1_val,
        output disp_s2_rdy, disp_s2_tag, disp_s2_val,
        output cdb_valid, cdb_tag, cdb_val, iss_ready,
        input  disp_ready, disp_tag, iss_valid, iss_op, iss_a, iss_b,
        input  iss_tag, free_count
    );

    modport slave (
        input  flush, disp_valid, disp_op,
        input  disp_s1_rdy, disp_s1_tag, disp_s1_val,
        input  disp_s2_rdy, disp_s2_tag, disp_s2_val,
        input  cdb_valid, cdb_tag, cdb_val, iss_ready,
        output disp_ready, disp_tag, iss_valid, iss_op, iss_a, iss_b,
        output iss_tag, free_count
    );
endinterface
`default_nettype wire

// File: rtl/rs_bank.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank
// Description : Reservation-station bank for one functional-unit class.
//               Allocates the lowest FREE entry per dispatch (tag =
//               BASE_TAG + index), wakes pending sources from the CDB
//               (including same-cycle dispatch bypass), issues the oldest
//               RDY entry over valid/ready, and keeps an issued entry's tag
//               reserved until the CDB broadcasts that tag.
//               Ports:
//                 clk  - clock, all state on posedge
//                 rst  - synchronous active-high reset
//                 bus  - rs_bank_if.slave (dispatch, CDB, issue, status)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_bank #(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 3,
    parameter int OPC_W       = 4,
    parameter int BASE_TAG    = 0
) (
    input  logic     clk,
    input  logic     rst,
    rs_bank_if.slave bus
);
    localparam int c_cnt_w = $clog2(NUM_ENTRIES + 1);
    localparam int c_idx_w = $clog2(NUM_ENTRIES);

    localparam logic [1:0] c_st_free   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_rdy    = 2'd2;
    localparam logic [1:0] c_st_issued = 2'd3;

    // Entry storage
    logic [1:0]             r_state  [NUM_ENTRIES];
    logic [OPC_W-1:0]       r_op     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_s1_rdy;
    logic [NUM_ENTRIES-1:0] r_s2_rdy;
    logic [TAG_W-1:0]       r_s1_tag [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_s2_tag [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_s1_val [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_s2_val [NUM_ENTRIES];
    // Age is kept as pairwise order: r_older[i][j] = 1 means entry j was
    // dispatched before entry i. This is exact regardless of how many
    // dispatches occur while a long-waiting entry stays live, so there is
    // no stamp wrap-around to reason about.
    logic [NUM_ENTRIES-1:0] r_older  [NUM_ENTRIES];

    logic [1:0]             w_nxt_state  [NUM_ENTRIES];
    logic [OPC_W-1:0]       w_nxt_op     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_nxt_s1_rdy;
    logic [NUM_ENTRIES-1:0] w_nxt_s2_rdy;
    logic [TAG_W-1:0]       w_nxt_s1_tag [NUM_ENTRIES];
    logic [TAG_W-1:0]       w_nxt_s2_tag [NUM_ENTRIES];
    logic [DATA_W-1:0]      w_nxt_s1_val [NUM_ENTRIES];
    logic [DATA_W-1:0]      w_nxt_s2_val [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] w_nxt_older  [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_free_vec;
    logic [NUM_ENTRIES-1:0] w_rdy_vec;
    logic [c_cnt_w-1:0]     w_free_count;
    logic [c_idx_w-1:0]     w_disp_idx;
    logic [c_idx_w-1:0]     w_iss_idx;
    logic                   w_any_free;
    logic                   w_iss_valid;
    logic                   w_disp_fire;
    logic                   w_iss_fire;
    logic                   w_d_s1_hit;
    logic                   w_d_s2_hit;
    logic                   w_d_s1_rdy;
    logic                   w_d_s2_rdy;
    logic [DATA_W-1:0]      w_d_s1_val;
    logic [DATA_W-1:0]      w_d_s2_val;

    // ------------------------------------------------------------------
    // Status vectors, allocation and issue selection
    // ------------------------------------------------------------------
    always_comb begin : p_status
        w_free_vec   = '0;
        w_rdy_vec    = '0;
        w_free_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free_vec[i] = (r_state[i] == c_st_free);
            w_rdy_vec[i]  = (r_state[i] == c_st_rdy);
            w_free_count  = w_free_count + c_cnt_w'(w_free_vec[i]);
        end
    end

    // Lowest-index FREE entry: scan downward so the lowest hit wins.
    always_comb begin : p_alloc
        w_disp_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_free_vec[i]) begin
                w_disp_idx = c_idx_w'(i);
            end
        end
    end

    // Oldest RDY entry: the one with no older RDY entry. Live entries are
    // totally ordered, so at most one entry qualifies.
    always_comb begin : p_pick
        w_iss_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_rdy_vec[i] && ((r_older[i] & w_rdy_vec) == '0)) begin
                w_iss_idx = c_idx_w'(i);
            end
        end
    end

    assign w_any_free  = |w_free_vec;
    assign w_iss_valid = |w_rdy_vec;
    assign w_disp_fire = bus.disp_valid && w_any_free;
    assign w_iss_fire  = w_iss_valid && bus.iss_ready;

    // Same-cycle bypass: a pending source whose producer is on the CDB now
    // is captured as ready. Sources that arrive ready keep their value.
    assign w_d_s1_hit = !bus.disp_s1_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_s1_tag);
    assign w_d_s2_hit = !bus.disp_s2_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_s2_tag);
    assign w_d_s1_rdy = bus.disp_s1_rdy || w_d_s1_hit;
    assign w_d_s2_rdy = bus.disp_s2_rdy || w_d_s2_hit;
    assign w_d_s1_val = w_d_s1_hit ? bus.cdb_val : bus.disp_s1_val;
    assign w_d_s2_val = w_d_s2_hit ? bus.cdb_val : bus.disp_s2_val;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.disp_ready = w_any_free;
    assign bus.disp_tag   = TAG_W'(BASE_TAG) + TAG_W'(w_disp_idx);
    assign bus.free_count = w_free_count;
    assign bus.iss_valid  = w_iss_valid;
    assign bus.iss_op     = w_iss_valid ? r_op[w_iss_idx]     : '0;
    assign bus.iss_a      = w_iss_valid ? r_s1_val[w_iss_idx] : '0;
    assign bus.iss_b      = w_iss_valid ? r_s2_val[w_iss_idx] : '0;
    assign bus.iss_tag    = w_iss_valid ? (TAG_W'(BASE_TAG) + TAG_W'(w_iss_idx)) : '0;

    // ------------------------------------------------------------------
    // Next-state logic for every entry
    // ------------------------------------------------------------------
    always_comb begin : p_next
        w_nxt_state  = r_state;
        w_nxt_op     = r_op;
        w_nxt_s1_rdy = r_s1_rdy;
        w_nxt_s2_rdy = r_s2_rdy;
        w_nxt_s1_tag = r_s1_tag;
        w_nxt_s2_tag = r_s2_tag;
        w_nxt_s1_val = r_s1_val;
        w_nxt_s2_val = r_s2_val;
        w_nxt_older  = r_older;

        if (bus.flush) begin
            // Dispatch, issue and CDB are all discarded in a flush cycle.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                w_nxt_state[i] = c_st_free;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                case (r_state[i])
                    c_st_wait: begin
                        if (bus.cdb_valid) begin
                            if (!r_s1_rdy[i] && (r_s1_tag[i] == bus.cdb_tag)) begin
                                w_nxt_s1_rdy[i] = 1'b1;
                                w_nxt_s1_val[i] = bus.cdb_val;
                            end
                            if (!r_s2_rdy[i] && (r_s2_tag[i] == bus.cdb_tag)) begin
                                w_nxt_s2_rdy[i] = 1'b1;
                                w_nxt_s2_val[i] = bus.cdb_val;
                            end
                            if (w_nxt_s1_rdy[i] && w_nxt_s2_rdy[i]) begin
                                w_nxt_state[i] = c_st_rdy;
                            end
                        end
                    end
                    c_st_rdy: begin
                        if (w_iss_fire && (w_iss_idx == c_idx_w'(i))) begin
                            w_nxt_state[i] = c_st_issued;
                        end
                    end
                    c_st_issued: begin
                        // The tag stays reserved until its own result is
                        // broadcast, so no other instruction can alias it.
                        if (bus.cdb_valid && (bus.cdb_tag == TAG_W'(BASE_TAG + i))) begin
                            w_nxt_state[i] = c_st_free;
                        end
                    end
                    default: ;
                endcase

                if (w_disp_fire) begin
                    if (w_disp_idx == c_idx_w'(i)) begin
                        w_nxt_state[i]  = (w_d_s1_rdy && w_d_s2_rdy) ? c_st_rdy : c_st_wait;
                        w_nxt_op[i]     = bus.disp_op;
                        w_nxt_s1_rdy[i] = w_d_s1_rdy;
                        w_nxt_s2_rdy[i] = w_d_s2_rdy;
                        w_nxt_s1_tag[i] = bus.disp_s1_tag;
                        w_nxt_s2_tag[i] = bus.disp_s2_tag;
                        w_nxt_s1_val[i] = w_d_s1_val;
                        w_nxt_s2_val[i] = w_d_s2_val;
                        // Every entry live now is older than the new one.
                        w_nxt_older[i]  = ~w_free_vec;
                    end else begin
                        w_nxt_older[i][w_disp_idx] = 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i]  <= c_st_free;
                r_op[i]     <= '0;
                r_s1_tag[i] <= '0;
                r_s2_tag[i] <= '0;
                r_s1_val[i] <= '0;
                r_s2_val[i] <= '0;
                r_older[i]  <= '0;
            end
            r_s1_rdy <= '0;
            r_s2_rdy <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_op     <= w_nxt_op;
            r_s1_rdy <= w_nxt_s1_rdy;
            r_s2_rdy <= w_nxt_s2_rdy;
            r_s1_tag <= w_nxt_s1_tag;
            r_s2_tag <= w_nxt_s2_tag;
            r_s1_val <= w_nxt_s1_val;
            r_s2_val <= w_nxt_s2_val;
            r_older  <= w_nxt_older;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rs_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_bank
// Description : Self-checking bench for rs_bank (4 entries, BASE_TAG 0).
//               Issued operations are compared against a queue of expected
//               issues; status outputs are compared directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_bank;
    localparam int c_n   = 4;
    localparam int c_dw  = 32;
    localparam int c_tw  = 3;
    localparam int c_ow  = 4;

    typedef struct {
        logic [c_tw-1:0] tag;
        logic [c_ow-1:0] op;
        logic [c_dw-1:0] a;
        logic [c_dw-1:0] b;
    } iss_t;

    typedef struct {
        logic [c_ow-1:0] op;
        logic [c_dw-1:0] a;
        logic [c_dw-1:0] b;
        logic [c_tw-1:0] exp_tag;
        logic [2:0]      exp_free;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    iss_t sb_q[$];
    iss_t mon_exp;
    vec_t vecs[4];

    rs_bank_if #(.NUM_ENTRIES(c_n), .DATA_W(c_dw), .TAG_W(c_tw), .OPC_W(c_ow)) bus ();

    rs_bank #(
        .NUM_ENTRIES(c_n), .DATA_W(c_dw), .TAG_W(c_tw), .OPC_W(c_ow), .BASE_TAG(0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic iss_t mk(input int tag, input int op, input logic [31:0] a, input logic [31:0] b);
        iss_t e;
        e.tag = c_tw'(tag);
        e.op  = c_ow'(op);
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    task automatic clear_inputs();
        bus.flush       = 1'b0;
        bus.disp_valid  = 1'b0;
        bus.disp_op     = '0;
        bus.disp_s1_rdy = 1'b0;
        bus.disp_s1_tag = '0;
        bus.disp_s1_val = '0;
        bus.disp_s2_rdy = 1'b0;
        bus.disp_s2_tag = '0;
        bus.disp_s2_val = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_val     = '0;
    endtask

    // Move to just after the next active edge and drop one-shot inputs.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic drive_disp(input int op, input logic s1r, input int s1t, input logic [31:0] s1v,
                              input logic s2r, input int s2t, input logic [31:0] s2v);
        bus.disp_valid  = 1'b1;
        bus.disp_op     = c_ow'(op);
        bus.disp_s1_rdy = s1r;
        bus.disp_s1_tag = c_tw'(s1t);
        bus.disp_s1_val = s1v;
        bus.disp_s2_rdy = s2r;
        bus.disp_s2_tag = c_tw'(s2t);
        bus.disp_s2_val = s2v;
    endtask

    task automatic drive_cdb(input int tag, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = c_tw'(tag);
        bus.cdb_val   = val;
    endtask

    // Scoreboard: every completed issue handshake must match the head of
    // the expected-issue queue.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.iss_valid && bus.iss_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_issue: got tag %0d, expected no issue", bus.iss_tag);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("sb_iss_tag", 64'(bus.iss_tag), 64'(mon_exp.tag));
                chk("sb_iss_op",  64'(bus.iss_op),  64'(mon_exp.op));
                chk("sb_iss_a",   64'(bus.iss_a),   64'(mon_exp.a));
                chk("sb_iss_b",   64'(bus.iss_b),   64'(mon_exp.b));
            end
        end
    end

    initial begin
        vecs[0] = '{op: 4'd1, a: 32'd5,          b: 32'd7,          exp_tag: 3'd0, exp_free: 3'd4};
        vecs[1] = '{op: 4'd2, a: 32'h11,         b: 32'h22,         exp_tag: 3'd1, exp_free: 3'd3};
        vecs[2] = '{op: 4'd3, a: 32'hFFFF_FFFF,  b: 32'h0,          exp_tag: 3'd2, exp_free: 3'd2};
        vecs[3] = '{op: 4'd4, a: 32'h1234_5678,  b: 32'h9ABC_DEF0,  exp_tag: 3'd3, exp_free: 3'd1};

        rst = 1'b1;
        bus.iss_ready = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("reset_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("reset_free_count", 64'(bus.free_count), 64'd4);
        chk("reset_iss_valid",  64'(bus.iss_valid),  64'd0);
        chk("reset_disp_tag",   64'(bus.disp_tag),   64'd0);
        chk("reset_iss_zero",   {bus.iss_op, bus.iss_tag, bus.iss_a, bus.iss_b} == '0 ? 64'd0 : 64'd1, 64'd0);

        // ---------------- table: ready dispatches, issue next cycle ------
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_disp(vecs[k].op, 1'b1, 0, vecs[k].a, 1'b1, 0, vecs[k].b);
            @(negedge clk);
            chk("vec_disp_tag",   64'(bus.disp_tag),   64'(vecs[k].exp_tag));
            chk("vec_free_count", 64'(bus.free_count), 64'(vecs[k].exp_free));
            chk("vec_no_same_cycle_issue", 64'(bus.iss_valid), 64'd0);
            sb_q.push_back(mk(int'(vecs[k].exp_tag), int'(vecs[k].op), vecs[k].a, vecs[k].b));
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        @(negedge clk);
        chk("issued_full_disp_ready", 64'(bus.disp_ready), 64'd0);
        chk("issued_full_free_count", 64'(bus.free_count), 64'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_cdb(k, 32'hDEAD_0000);
            next_cycle();
            @(negedge clk);
            chk("cdb_free_count", 64'(bus.free_count), 64'(k + 1));
        end

        // ---------------- wakeup: younger ready entry goes first ----------
        next_cycle();
        drive_disp(5, 1'b0, 6, 32'h0, 1'b1, 0, 32'h3);
        @(negedge clk);
        chk("wake_disp_tag0", 64'(bus.disp_tag), 64'd0);
        next_cycle();
        drive_disp(6, 1'b1, 0, 32'h21, 1'b1, 0, 32'h22);
        @(negedge clk);
        chk("wake_disp_tag1", 64'(bus.disp_tag), 64'd1);
        chk("wake_waiting_not_valid", 64'(bus.iss_valid), 64'd0);
        sb_q.push_back(mk(1, 6, 32'h21, 32'h22));
        next_cycle();
        drive_cdb(6, 32'h10);
        sb_q.push_back(mk(0, 5, 32'h10, 32'h3));
        @(negedge clk);
        next_cycle();
        drive_cdb(1, 32'h0);
        @(negedge clk);
        next_cycle();
        drive_cdb(0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("wake_free_count", 64'(bus.free_count), 64'd4);

        // ---------------- dispatch bypass from CDB ----------------
        next_cycle();
        drive_disp(7, 1'b1, 5, 32'h33, 1'b0, 5, 32'h0);
        drive_cdb(5, 32'hAB);
        sb_q.push_back(mk(0, 7, 32'h33, 32'hAB));
        @(negedge clk);
        chk("bypass_disp_tag", 64'(bus.disp_tag), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("bypass_iss_valid", 64'(bus.iss_valid), 64'd1);
        chk("bypass_iss_b",     64'(bus.iss_b),     64'hAB);
        next_cycle();
        drive_cdb(0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("bypass_free_count", 64'(bus.free_count), 64'd4);

        // ---------------- fill, drop, reuse a freed tag ----------------
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 2) drive_disp(8 + k, 1'b1, 0, 32'h40 + 32'(k), 1'b1, 0, 32'h50 + 32'(k));
            else        drive_disp(8 + k, 1'b0, 7, 32'h0,           1'b1, 0, 32'h50 + 32'(k));
            @(negedge clk);
            chk("fill_disp_tag", 64'(bus.disp_tag), 64'(k));
        end
        next_cycle();
        drive_disp(12, 1'b1, 0, 32'h99, 1'b1, 0, 32'h98);
        @(negedge clk);
        chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
        chk("full_free_count", 64'(bus.free_count), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("full_drop_count", 64'(bus.free_count), 64'd0);
        next_cycle();
        bus.iss_ready = 1'b1;
        sb_q.push_back(mk(2, 10, 32'h42, 32'h52));
        @(negedge clk);
        next_cycle();
        bus.iss_ready = 1'b0;
        drive_cdb(2, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("reopen_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("reopen_free_count", 64'(bus.free_count), 64'd1);
        chk("reopen_disp_tag",   64'(bus.disp_tag),   64'd2);
        next_cycle();
        drive_disp(13, 1'b0, 7, 32'h0, 1'b1, 0, 32'h63);
        @(negedge clk);
        chk("redisp_tag", 64'(bus.disp_tag), 64'd2);
        next_cycle();
        drive_cdb(7, 32'h77);
        bus.iss_ready = 1'b1;
        // Reused entry 2 is youngest even though its index is lower than 3.
        sb_q.push_back(mk(0, 8,  32'h77, 32'h50));
        sb_q.push_back(mk(1, 9,  32'h77, 32'h51));
        sb_q.push_back(mk(3, 11, 32'h77, 32'h53));
        sb_q.push_back(mk(2, 13, 32'h77, 32'h63));
        repeat (4) begin
            next_cycle();
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive_cdb(k, 32'h0);
        end
        next_cycle();
        @(negedge clk);
        chk("reuse_free_count", 64'(bus.free_count), 64'd4);

        // ---------------- age beats index while stalled ----------------
        bus.iss_ready = 1'b0;
        next_cycle();
        drive_disp(1, 1'b1, 0, 32'hA0, 1'b1, 0, 32'hA1);
        @(negedge clk);
        chk("age_first_tag", 64'(bus.disp_tag), 64'd0);
        next_cycle();
        bus.iss_ready = 1'b1;
        sb_q.push_back(mk(0, 1, 32'hA0, 32'hA1));
        drive_disp(2, 1'b1, 0, 32'hB0, 1'b1, 0, 32'hB1);
        @(negedge clk);
        chk("age_old_tag", 64'(bus.disp_tag), 64'd1);
        next_cycle();
        bus.iss_ready = 1'b0;
        drive_cdb(0, 32'h0);
        next_cycle();
        drive_disp(3, 1'b1, 0, 32'hC0, 1'b1, 0, 32'hC1);
        @(negedge clk);
        chk("age_new_tag", 64'(bus.disp_tag), 64'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            chk("age_hold_tag", 64'(bus.iss_tag), 64'd1);
            chk("age_hold_a",   64'(bus.iss_a),   64'hB0);
        end
        next_cycle();
        bus.iss_ready = 1'b1;
        sb_q.push_back(mk(1, 2, 32'hB0, 32'hB1));
        sb_q.push_back(mk(0, 3, 32'hC0, 32'hC1));
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        drive_cdb(1, 32'h0);
        next_cycle();
        drive_cdb(0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("age_free_count", 64'(bus.free_count), 64'd4);

        // ---------------- flush mid-operation ----------------
        bus.iss_ready = 1'b0;
        next_cycle();
        drive_disp(1, 1'b1, 0, 32'h1, 1'b1, 0, 32'h2);
        next_cycle();
        drive_disp(2, 1'b0, 6, 32'h0, 1'b1, 0, 32'h3);
        next_cycle();
        drive_disp(3, 1'b1, 0, 32'h4, 1'b1, 0, 32'h5);
        next_cycle();
        @(negedge clk);
        chk("flush_live_count", 64'(bus.free_count), 64'd1);
        next_cycle();
        bus.flush = 1'b1;
        bus.iss_ready = 1'b1;
        drive_disp(4, 1'b1, 0, 32'h6, 1'b1, 0, 32'h7);
        drive_cdb(6, 32'h8);
        @(negedge clk);
        next_cycle();
        bus.iss_ready = 1'b0;
        @(negedge clk);
        chk("flush_free_count", 64'(bus.free_count), 64'd4);
        chk("flush_iss_valid",  64'(bus.iss_valid),  64'd0);
        chk("flush_disp_ready", 64'(bus.disp_ready), 64'd1);

        // ---------------- reset during a dispatch ----------------
        next_cycle();
        drive_disp(5, 1'b1, 0, 32'h9, 1'b1, 0, 32'hA);
        next_cycle();
        drive_disp(6, 1'b1, 0, 32'hB, 1'b1, 0, 32'hC);
        next_cycle();
        rst = 1'b1;
        drive_disp(7, 1'b1, 0, 32'hD, 1'b1, 0, 32'hE);
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_free_count", 64'(bus.free_count), 64'd4);
        chk("rst_iss_valid",  64'(bus.iss_valid),  64'd0);
        chk("rst_disp_tag",   64'(bus.disp_tag),   64'd0);
        chk("rst_iss_a",      64'(bus.iss_a),      64'd0);

        next_cycle();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
